// File: rtl/spc_stack.sv
// spc_stack: subroutine-PC return-address LIFO for the microsequencer.
// Registered top-of-stack, saturating occupancy pointer, sticky error flags.
//
// Ports:
//   CLK      rising-edge clock
//   RESET_N  asynchronous reset, active low
//   PUSH     write DIN as new top (call)
//   POP      discard top (return); PUSH+POP replaces the top
//   DIN      return PC to push
//   DOUT     registered top-of-stack, 0 when empty
//   PTR      occupancy, 0..DEPTH
//   EMPTY    PTR == 0
//   FULL     PTR == DEPTH
//   OVF      sticky: push refused while full
//   UNF      sticky: pop refused while empty
//   CLR_ERR  synchronous clear of OVF/UNF (a same-edge error wins)
module spc_stack #(
    parameter int DATA_W = 19,
    parameter int PTR_W  = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic [PTR_W:0]    PTR,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVF,
    output logic              UNF,
    input  logic              CLR_ERR
);

    localparam int DEPTH = 1 << PTR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W:0]   ptr_m1;
    logic [PTR_W:0]   ptr_m2;
    logic             ovf_set;
    logic             unf_set;

    // The pointer saturates at DEPTH, so its MSB alone marks FULL.
    assign EMPTY = (PTR == '0);
    assign FULL  = PTR[PTR_W];

    assign ptr_m1 = PTR - (PTR_W+1)'(1);
    assign ptr_m2 = PTR - (PTR_W+1)'(2);

    // PUSH+POP on an empty stack has nothing to replace: plain push.
    assign do_push = PUSH & ~FULL & (~POP | EMPTY);
    assign do_pop  = POP & ~PUSH & ~EMPTY;
    assign do_repl = PUSH & POP & ~EMPTY;
    assign ovf_set = PUSH & ~POP & FULL;
    assign unf_set = POP & ~PUSH & EMPTY;

    assign wr_en  = do_push | do_repl;
    assign wr_idx = do_repl ? ptr_m1[PTR_W-1:0] : PTR[PTR_W-1:0];

    // Storage is deliberately not reset; DOUT masks stale entries.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PTR  <= '0;
            DOUT <= '0;
        end else begin
            unique case (1'b1)
                do_push: begin
                    PTR  <= PTR + (PTR_W+1)'(1);
                    DOUT <= DIN;
                end
                do_repl: begin
                    DOUT <= DIN;
                end
                do_pop: begin
                    PTR <= ptr_m1;
                    // Next top is two below the current pointer.
                    if (PTR >= (PTR_W+1)'(2)) begin
                        DOUT <= mem[ptr_m2[PTR_W-1:0]];
                    end else begin
                        DOUT <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            if (ovf_set) begin
                OVF <= 1'b1;
            end else if (CLR_ERR) begin
                OVF <= 1'b0;
            end
            if (unf_set) begin
                UNF <= 1'b1;
            end else if (CLR_ERR) begin
                UNF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spc_stack.sv
// tb_spc_stack: directed self-checking bench for spc_stack.
// Hand-computed expectations for push/pop/replace, limits, flags and reset.
module tb_spc_stack;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic [18:0] din;
    logic [18:0] dout;
    logic [5:0]  ptr;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        clr_err;

    int n_chk;
    int n_pass;

    spc_stack #(
        .DATA_W(19),
        .PTR_W (5)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .PUSH   (push),
        .POP    (pop),
        .DIN    (din),
        .DOUT   (dout),
        .PTR    (ptr),
        .EMPTY  (empty),
        .FULL   (full),
        .OVF    (ovf),
        .UNF    (unf),
        .CLR_ERR(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation across a rising edge, sample 1ns later.
    task automatic step(input logic p, input logic q,
                        input logic [18:0] d, input logic c);
        push    = p;
        pop     = q;
        din     = d;
        clr_err = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        din     = '0;
        clr_err = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_ptr", 32'(ptr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);

        // 1: async reset mid-cycle clears state and flags
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t1_unf_set", 32'(unf), 1);
        step(1'b1, 1'b0, 19'h5, 1'b0);
        chk("t1_ptr_pre", 32'(ptr), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_ptr", 32'(ptr), 0);
        chk("t1_dout", 32'(dout), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_unf", 32'(unf), 0);
        rst_n = 1'b1;

        // 2: push three, pop three
        step(1'b1, 1'b0, 19'h00011, 1'b0);
        chk("t2_d1", 32'(dout), 32'h11);
        chk("t2_p1", 32'(ptr), 1);
        step(1'b1, 1'b0, 19'h00022, 1'b0);
        chk("t2_d2", 32'(dout), 32'h22);
        chk("t2_p2", 32'(ptr), 2);
        step(1'b1, 1'b0, 19'h00033, 1'b0);
        chk("t2_d3", 32'(dout), 32'h33);
        chk("t2_p3", 32'(ptr), 3);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t2_d4", 32'(dout), 32'h22);
        chk("t2_p4", 32'(ptr), 2);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t2_d5", 32'(dout), 32'h11);
        chk("t2_p5", 32'(ptr), 1);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t2_d6", 32'(dout), 0);
        chk("t2_p6", 32'(ptr), 0);
        chk("t2_empty", 32'(empty), 1);

        // 3: fill, overflow, drain
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 19'(i), 1'b0);
            chk("t3_fill_ptr", 32'(ptr), 32'(i + 1));
        end
        chk("t3_full", 32'(full), 1);
        chk("t3_ptr", 32'(ptr), 32);
        chk("t3_dout", 32'(dout), 31);
        step(1'b1, 1'b0, 19'h7FFFF, 1'b0);
        chk("t3_ovf", 32'(ovf), 1);
        chk("t3_ovf_ptr", 32'(ptr), 32);
        chk("t3_ovf_dout", 32'(dout), 31);
        for (int k = 1; k <= 32; k++) begin
            step(1'b0, 1'b1, 19'h0, 1'b0);
            chk("t3_drain_ptr", 32'(ptr), 32'(32 - k));
            chk("t3_drain_dout", 32'(dout),
                (k < 32) ? 32'(31 - k) : 32'd0);
        end
        chk("t3_empty", 32'(empty), 1);
        chk("t3_unf", 32'(unf), 0);
        step(1'b0, 1'b0, 19'h0, 1'b1);
        chk("t3_ovf_clr", 32'(ovf), 0);

        // 4: underflow, clear, set-wins-over-clear
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t4_unf", 32'(unf), 1);
        chk("t4_ptr", 32'(ptr), 0);
        step(1'b0, 1'b0, 19'h0, 1'b1);
        chk("t4_clr", 32'(unf), 0);
        step(1'b0, 1'b1, 19'h0, 1'b1);
        chk("t4_set_wins", 32'(unf), 1);
        chk("t4_ptr2", 32'(ptr), 0);
        step(1'b0, 1'b0, 19'h0, 1'b1);
        chk("t4_clr2", 32'(unf), 0);

        // 5: replace top, push+pop on empty
        step(1'b1, 1'b0, 19'hA, 1'b0);
        chk("t5_pa", 32'(dout), 32'hA);
        step(1'b1, 1'b1, 19'hB, 1'b0);
        chk("t5_rp_ptr", 32'(ptr), 1);
        chk("t5_rp_dout", 32'(dout), 32'hB);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t5_pop_empty", 32'(empty), 1);
        chk("t5_pop_dout", 32'(dout), 0);
        step(1'b1, 1'b1, 19'hC, 1'b0);
        chk("t5_e_ptr", 32'(ptr), 1);
        chk("t5_e_dout", 32'(dout), 32'hC);
        chk("t5_e_unf", 32'(unf), 0);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t5_end", 32'(ptr), 0);

        // 6: reset while PUSH held, stale contents hidden
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 19'(32'h100 + i);
            @(posedge clk);
            #1;
        end
        chk("t6_pre_ptr", 32'(ptr), 5);
        chk("t6_pre_dout", 32'(dout), 32'h104);
        rst_n = 1'b0;
        #1;
        chk("t6_ptr", 32'(ptr), 0);
        chk("t6_dout", 32'(dout), 0);
        @(posedge clk);
        #1;
        chk("t6_hold_ptr", 32'(ptr), 0);
        push  = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 19'h1, 1'b0);
        chk("t6_p_ptr", 32'(ptr), 1);
        chk("t6_p_dout", 32'(dout), 1);
        step(1'b0, 1'b1, 19'h0, 1'b0);
        chk("t6_pop_dout", 32'(dout), 0);
        chk("t6_pop_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
